module_bin2bcd_seq: RTL and testbench

//  Parametrised sequential binary-to-BCD converter (shift-add-3 / double-dabble).

---
 rtl/module_bin2bcd_seq.sv | 102 ++++++++++
 tb/tb_module_bin2bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/module_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define DIV_SAT_EN to clamp overflowing results to all nines instead of value mod 10^DIGITS.
module module_bin2bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      numero_input,
   input  logic                  valido_input,
   output logic [4*DIGITS-1:0]   bcd_output,
   output logic                  listo_output,
   output logic                  ocupado_output,
   output logic                  desborde_output
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_q;
   logic [BCD_W-1:0]   acc_q;
   logic [BCD_W-1:0]   acc_adj;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;

   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] r;
      r = acc;
      for (int k = 0; k < DIGITS; k++) begin
         if (acc[4*k +: 4] >= 4'd5)
            r[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

`ifdef DIV_SAT_EN
   function automatic logic [BCD_W-1:0] sat_result(input logic [BCD_W-1:0] acc,
                                                    input logic ovf);
      return ovf ? {DIGITS{4'h9}} : acc;
   endfunction
`endif

   assign acc_adj        = add3_digits(acc_q);
   assign ocupado_output = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valido_input) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         bin_q           <= '0;
         acc_q           <= '0;
         cnt_q           <= '0;
         ovf_q           <= 1'b0;
         bcd_output      <= '0;
         listo_output    <= 1'b0;
         desborde_output <= 1'b0;
      end else begin
         state_q      <= state_d;
         listo_output <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valido_input) begin
                  bin_q <= numero_input;
                  acc_q <= '0;
                  cnt_q <= '0;
                  ovf_q <= 1'b0;
               end
            end
            SHIFT: begin
               // The bit leaving the top digit is a lost multiple of 10^DIGITS.
               {acc_q, bin_q} <= {acc_adj[BCD_W-2:0], bin_q, 1'b0};
               ovf_q          <= ovf_q | acc_adj[BCD_W-1];
               cnt_q          <= cnt_q + CNT_W'(1);
            end
            DONE: begin
`ifdef DIV_SAT_EN
               bcd_output <= sat_result(acc_q, ovf_q);
`else
               bcd_output <= acc_q;
`endif
               desborde_output <= ovf_q;
               listo_output    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_module_bin2bcd_seq.sv
// Bench for module_bin2bcd_seq: a 5-digit and a 4-digit instance, scoreboard-checked.
// Expected 4-digit overflow results follow DIV_SAT_EN when it is defined.
module tb_module_bin2bcd_seq;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  num = '0, num4 = '0;
   logic          vld = 1'b0, vld4 = 1'b0;
   logic [19:0]   bcd;
   logic [15:0]   bcd4;
   logic          listo, ocup, desb;
   logic          listo4, ocup4, desb4;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_listo = -1;
   bit chk_spacing = 1'b0;

   typedef struct {logic [31:0] bcd; logic ovf; int acc;} sb_t;
   typedef struct {logic [15:0] num; logic [19:0] bcd; logic ovf;} vec_t;
   sb_t  q5[$];
   sb_t  q4[$];
   vec_t vecs[9];
   vec_t vecs4[5];

   module_bin2bcd_seq #(.WIDTH(W), .DIGITS(5)) dut (
      .clk(clk), .rst(rst), .numero_input(num), .valido_input(vld),
      .bcd_output(bcd), .listo_output(listo), .ocupado_output(ocup),
      .desborde_output(desb));

   module_bin2bcd_seq #(.WIDTH(W), .DIGITS(4)) dut4 (
      .clk(clk), .rst(rst), .numero_input(num4), .valido_input(vld4),
      .bcd_output(bcd4), .listo_output(listo4), .ocupado_output(ocup4),
      .desborde_output(desb4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] exp4(input logic [15:0] modv, input logic ovf);
`ifdef DIV_SAT_EN
      return ovf ? 16'h9999 : modv;
`else
      return modv;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst && listo) begin
         sb_t e;
         if (q5.size() == 0) chk("unexpected listo (5 digits)", 32'd1, 32'd0);
         else begin
            e = q5.pop_front();
            chk("bcd5", 32'(bcd), e.bcd);
            chk("desborde5", 32'(desb), 32'(e.ovf));
            chk("latency5", 32'(cyc - e.acc), 32'(W + 1));
            if (chk_spacing && last_listo >= 0)
               chk("spacing5", 32'(cyc - last_listo), 32'(W + 2));
         end
         last_listo = cyc;
      end
      if (rst && listo4) begin
         sb_t e;
         if (q4.size() == 0) chk("unexpected listo (4 digits)", 32'd1, 32'd0);
         else begin
            e = q4.pop_front();
            chk("bcd4", 32'(bcd4), e.bcd);
            chk("desborde4", 32'(desb4), 32'(e.ovf));
            chk("latency4", 32'(cyc - e.acc), 32'(W + 1));
         end
      end
   end

   task automatic send5(input logic [15:0] v, input logic [19:0] eb, input logic eo);
      int t = 0;
      while (ocup && t < 100) begin @(negedge clk); t++; end
      if (ocup) begin chk("send5 timeout", 32'd1, 32'd0); return; end
      num = v;
      vld = 1'b1;
      q5.push_back('{32'(eb), eo, cyc + 1});
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic send4(input logic [15:0] v, input logic [15:0] eb, input logic eo);
      int t = 0;
      while (ocup4 && t < 100) begin @(negedge clk); t++; end
      if (ocup4) begin chk("send4 timeout", 32'd1, 32'd0); return; end
      num4 = v;
      vld4 = 1'b1;
      q4.push_back('{32'(eb), eo, cyc + 1});
      @(negedge clk);
      vld4 = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q5.size() != 0 || q4.size() != 0) && t < 200) begin @(negedge clk); t++; end
      if (q5.size() != 0 || q4.size() != 0) begin
         chk("drain timeout", 32'(q5.size() + q4.size()), 32'd0);
         q5.delete();
         q4.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int t;
      vecs = '{'{16'd1007,  20'h01007, 1'b0}, '{16'd5004,  20'h05004, 1'b0},
               '{16'd4346,  20'h04346, 1'b0}, '{16'd1208,  20'h01208, 1'b0},
               '{16'd65535, 20'h65535, 1'b0}, '{16'd0,     20'h00000, 1'b0},
               '{16'd9,     20'h00009, 1'b0}, '{16'd10,    20'h00010, 1'b0},
               '{16'd59999, 20'h59999, 1'b0}};
      vecs4 = '{'{16'd12345, 20'(exp4(16'h2345, 1'b1)), 1'b1},
                '{16'd9999,  20'(exp4(16'h9999, 1'b0)), 1'b0},
                '{16'd10000, 20'(exp4(16'h0000, 1'b1)), 1'b1},
                '{16'd65535, 20'(exp4(16'h5535, 1'b1)), 1'b1},
                '{16'd0,     20'(exp4(16'h0000, 1'b0)), 1'b0}};

      // reset held, then released with no request
      repeat (3) @(negedge clk);
      chk("reset bcd", 32'(bcd), 32'd0);
      chk("reset listo", 32'(listo), 32'd0);
      chk("reset ocupado", 32'(ocup), 32'd0);
      chk("reset desborde", 32'(desb), 32'd0);
      chk("reset bcd4", 32'(bcd4), 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle ocupado", 32'(ocup), 32'd0);
      chk("idle listo", 32'(listo), 32'd0);
      chk("idle bcd", 32'(bcd), 32'd0);

      // table: sent back to back, each on the listo cycle of the previous one
      chk_spacing = 1'b1;
      last_listo  = -1;
      for (int i = 0; i < 9; i++) send5(vecs[i].num, vecs[i].bcd, vecs[i].ovf);
      drain();
      chk_spacing = 1'b0;

      // reset five cycles into a conversion aborts it
      num = 16'd4346;
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy before abort", 32'(ocup), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort bcd", 32'(bcd), 32'd0);
      chk("abort ocupado", 32'(ocup), 32'd0);
      chk("abort listo", 32'(listo), 32'd0);
      chk("abort desborde", 32'(desb), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("no result after abort", 32'(bcd), 32'd0);
      send5(16'd1208, 20'h01208, 1'b0);
      drain();

      // valido held high, input changed mid-conversion
      num = 16'd1007;
      vld = 1'b1;
      q5.push_back('{32'h01007, 1'b0, cyc + 1});
      repeat (4) @(negedge clk);
      num = 16'd0;
      t = 0;
      while (!listo && t < 100) begin @(negedge clk); t++; end
      if (!listo) chk("held-valid listo timeout", 32'd1, 32'd0);
      else begin
         chk("ocupado low on listo", 32'(ocup), 32'd0);
         q5.push_back('{32'h00000, 1'b0, cyc + 1});
      end
      @(negedge clk);
      vld = 1'b0;
      drain();

      // four-digit overflow cases
      for (int i = 0; i < 5; i++) send4(vecs4[i].num, vecs4[i].bcd[15:0], vecs4[i].ovf);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
